// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues one word read at a time,
// buffers returned words in a small prefetch FIFO and presents them to the datapath.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [31:0]                instr_pc4,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state_r, state_s;
    logic [31:0]   fetch_pc_r, fetch_pc_s;
    logic [31:0]   addr_r, addr_s;
    logic          req_r, req_s;
    logic [CW-1:0] count_r, count_s;
    logic [CW-1:0] avail_s;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   target_s;
    logic          pop_s, push_s;
    logic          unused_s;

    assign unused_s = ^redirect_pc[1:0];
    assign target_s = {redirect_pc[31:2], 2'b00};
    assign pop_s    = (count_r != {CW{1'b0}}) & instr_ready;
    assign push_s   = (state_r == REQ) & imem_ack & ~redirect;
    // Occupancy once this cycle's pop has been taken into account.
    assign avail_s  = count_r - CW'(pop_s);

    // Next-state, fetch PC, request address and occupancy.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        addr_s     = addr_r;
        count_s    = count_r;
        if (redirect) begin
            fetch_pc_s = target_s;
            count_s    = {CW{1'b0}};
            case (state_r)
                IDLE: begin
                    state_s = REQ;
                    addr_s  = target_s;
                end
                REQ, DRAIN: begin
                    // An in-flight request must complete before the new target is issued.
                    if (imem_ack) begin
                        state_s = REQ;
                        addr_s  = target_s;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    count_s = avail_s;
                    if (avail_s < DEPTH_C) begin
                        state_s = REQ;
                        addr_s  = fetch_pc_r;
                    end else begin
                        state_s = IDLE;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        count_s    = avail_s + CW'(1);
                        fetch_pc_s = fetch_pc_r + 32'd4;
                        if ((avail_s + CW'(1)) < DEPTH_C) begin
                            state_s = REQ;
                            addr_s  = fetch_pc_r + 32'd4;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        count_s = avail_s;
                    end
                end
                DRAIN: begin
                    count_s = avail_s;
                    if (imem_ack) begin
                        state_s = REQ;
                        addr_s  = fetch_pc_r;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = avail_s;
                end
            endcase
        end
        req_s = (state_s != IDLE);
    end

    // Control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            count_r    <= {CW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
            count_r    <= count_s;
            if (redirect) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                wr_ptr_r <= wr_ptr_r + AW'(push_s);
                rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            end
        end
    end

    // Prefetch storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_valid = (count_r != {CW{1'b0}});
    assign instr       = instr_mem_r[rd_ptr_r];
    assign instr_pc    = pc_mem_r[rd_ptr_r];
    assign instr_pc4   = pc_mem_r[rd_ptr_r] + 32'd4;
    assign fifo_count  = count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr, instr_pc, instr_pc4;
    logic        instr_ready = 1'b1;
    logic [2:0]  fifo_count;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc42;
    logic        ready2 = 1'b1;
    logic [2:0]  count2;

    int latency = 0;
    int wait_cnt = 0;
    int ack_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign imem_ack   = imem_req && (wait_cnt >= latency);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign ack2       = req2;
    assign rdata2     = addr2 ^ 32'hA5A5_0000;

    // Memory latency model and ack counter.
    always @(posedge clock) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
        if (imem_req && imem_ack)  ack_cnt  <= ack_cnt + 1;
    end

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_ready(instr_ready),
        .fifo_count(fifo_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clock(clock), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .redirect(1'b0),
        .redirect_pc(32'h0000_0000), .instr_valid(valid2), .instr(instr2),
        .instr_pc(pc2), .instr_pc4(pc42), .instr_ready(ready2),
        .fifo_count(count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Assert reset for two cycles and release at a falling edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc4", instr_pc4, 32'h4);
        check("rst_count", {29'b0, fifo_count}, 32'd0);
        check("rst_addr2", addr2, 32'hFFFF_FFF8);

        // Test 1 and 5: zero-wait streaming
        reset = 1'b1;
        @(negedge clock);
        check("t1_req", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t1_valid", {31'b0, instr_valid}, 32'd1);
            check("t1_pc", instr_pc, 32'(4 * i));
            check("t1_instr", instr, 32'(4 * i) ^ 32'hA5A5_0000);
            check("t1_pc4", instr_pc4, 32'(4 * i + 4));
            check("t1_addr", imem_addr, 32'(4 * i + 4));
            check("t5_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * i));
            check("t5_pc4", pc42, 32'hFFFF_FFFC + 32'(4 * i));
        end

        // Test 6: asynchronous reset mid-request
        #2 reset = 1'b0;
        #1;
        check("t6_req", {31'b0, imem_req}, 32'd0);
        check("t6_valid", {31'b0, instr_valid}, 32'd0);
        check("t6_count", {29'b0, fifo_count}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_req1", {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        @(negedge clock);
        check("t6_pc", instr_pc, 32'h0);

        // Test 2: backpressure fills the FIFO
        instr_ready = 1'b0;
        do_reset();
        base = ack_cnt;
        repeat (10) @(negedge clock);
        check("t2_acks", 32'(ack_cnt - base), 32'd4);
        check("t2_req", {31'b0, imem_req}, 32'd0);
        check("t2_count", {29'b0, fifo_count}, 32'd4);
        check("t2_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check("t2_drain", instr_pc, 32'(4 * i));
        end

        // Test 3: redirect while a slow request is outstanding
        latency = 3;
        do_reset();
        @(negedge clock);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clock);
        redirect = 1'b0;
        check("t3_req", {31'b0, imem_req}, 32'd1);
        check("t3_hold0", imem_addr, 32'h0);
        @(negedge clock);
        check("t3_hold1", imem_addr, 32'h0);
        @(negedge clock);
        check("t3_ack", {31'b0, imem_ack}, 32'd1);
        check("t3_hold2", imem_addr, 32'h0);
        @(negedge clock);
        check("t3_newaddr", imem_addr, 32'h0000_0100);
        check("t3_novalid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clock);
        check("t3_valid", {31'b0, instr_valid}, 32'd1);
        check("t3_pc", instr_pc, 32'h0000_0100);
        check("t3_instr", instr, 32'h0000_0100 ^ 32'hA5A5_0000);

        // Test 4: redirect coinciding with ack and pop at count 2
        latency = 0;
        instr_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clock);
        check("t4_count2", {29'b0, fifo_count}, 32'd2);
        check("t4_ackhi", {31'b0, imem_ack}, 32'd1);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clock);
        redirect = 1'b0;
        check("t4_count0", {29'b0, fifo_count}, 32'd0);
        check("t4_valid0", {31'b0, instr_valid}, 32'd0);
        check("t4_addr", imem_addr, 32'h0000_0200);
        @(negedge clock);
        check("t4_valid", {31'b0, instr_valid}, 32'd1);
        check("t4_pc", instr_pc, 32'h0000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
